// File: rtl/banked_register_file.sv
// Register bank with two tri-state read buses, a sized write port and a
// post-increment/pre-decrement adjust port. Priority: reset > write > adjust.
module banked_register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned SP_INDEX = NREGS - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_a,
  input  logic [$clog2(NREGS)-1:0] sel_a,
  input  logic                     en_b,
  input  logic [$clog2(NREGS)-1:0] sel_b,
  input  logic                     s,
  input  logic [$clog2(NREGS)-1:0] sel_w,
  input  logic [1:0]               size,
  input  logic                     sext,
  input  logic [WIDTH-1:0]         d,
  input  logic                     adj,
  input  logic                     adj_dec,
  input  logic [$clog2(NREGS)-1:0] sel_adj,
  output logic [WIDTH-1:0]         q_a,
  output logic [WIDTH-1:0]         q_b
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             sel_a_ok, sel_b_ok, sel_w_ok, sel_adj_ok;
  logic [WIDTH-1:0] rd_a, rd_b, wr_old, wr_val, adj_old, adj_step, adj_val;

  assign sel_a_ok   = 32'(sel_a) < NREGS;
  assign sel_b_ok   = 32'(sel_b) < NREGS;
  assign sel_w_ok   = 32'(sel_w) < NREGS;
  assign sel_adj_ok = 32'(sel_adj) < NREGS;

  // Out-of-range selects read as unknown rather than aliasing a real register.
  assign rd_a = sel_a_ok ? regs_q[sel_a] : 'x;
  assign rd_b = sel_b_ok ? regs_q[sel_b] : 'x;

  assign q_a = en_a ? rd_a : 'z;
  assign q_b = en_b ? rd_b : 'z;

  assign wr_old  = sel_w_ok ? regs_q[sel_w] : '0;
  assign adj_old = sel_adj_ok ? regs_q[sel_adj] : '0;

  always_comb begin
    wr_val = d;
    unique case (size)
      2'b00: wr_val = sext ? {{(WIDTH - 8){d[7]}}, d[7:0]} : {wr_old[WIDTH-1:8], d[7:0]};
      2'b01: wr_val = sext ? {{(WIDTH - 16){d[15]}}, d[15:0]} : {wr_old[WIDTH-1:16], d[15:0]};
      default: wr_val = d;
    endcase
  end

  always_comb begin
    adj_step = WIDTH'(4);
    unique case (size)
      // The stack pointer stays word aligned even for byte-sized pushes/pops.
      2'b00:   adj_step = (32'(sel_adj) == SP_INDEX) ? WIDTH'(2) : WIDTH'(1);
      2'b01:   adj_step = WIDTH'(2);
      default: adj_step = WIDTH'(4);
    endcase
  end

  assign adj_val = adj_dec ? (adj_old - adj_step) : (adj_old + adj_step);

  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (adj && sel_adj_ok) begin
      regs_d[sel_adj] = adj_val;
    end
    // Applied last so a write to the same register discards the adjust.
    if (s && sel_w_ok) begin
      regs_d[sel_w] = wr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: vector table plus hand sequences
// for read-during-write, held strobes and asynchronous reset.
module tb_banked_register_file;

  logic        clk, reset;
  logic        en_a, en_b, s, sext, adj, adj_dec;
  logic [2:0]  sel_a, sel_b, sel_w, sel_adj;
  logic [1:0]  size;
  logic [31:0] d;
  wire  [31:0] q_a, q_b;

  int checks = 0;
  int errors = 0;

  banked_register_file #(.WIDTH(32), .NREGS(8), .SP_INDEX(7)) dut (
    .clk(clk), .reset(reset), .en_a(en_a), .sel_a(sel_a), .en_b(en_b), .sel_b(sel_b),
    .s(s), .sel_w(sel_w), .size(size), .sext(sext), .d(d), .adj(adj), .adj_dec(adj_dec),
    .sel_adj(sel_adj), .q_a(q_a), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [2:0]  sel_w;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] d;
    logic        adj;
    logic        adj_dec;
    logic [2:0]  sel_adj;
    logic [2:0]  ra;
    logic [31:0] ea;
    logic [2:0]  rb;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // A released bus is z in a 4-state simulator and resolves to 0 in a 2-state one.
  task automatic check_float(input string name, input logic [31:0] act);
    checks++;
    if (!(act === 32'hzzzzzzzz || act === 32'h0)) begin
      errors++;
      $display("FAIL %s got %h expected bus released (z)", name, act);
    end
  endtask

  task automatic idle();
    s = 0; adj = 0; adj_dec = 0; sext = 0; size = 2'b10; d = '0;
    sel_w = 0; sel_adj = 0;
  endtask

  initial begin
    vecs[0]  = '{1, 2, 2'b10, 0, 32'h12345678, 0, 0, 0, 2, 32'h12345678, 0, 32'h0};
    vecs[1]  = '{1, 2, 2'b00, 0, 32'hFFFFFFAB, 0, 0, 0, 2, 32'h123456AB, 2, 32'h123456AB};
    vecs[2]  = '{1, 2, 2'b01, 1, 32'h00008001, 0, 0, 0, 2, 32'hFFFF8001, 0, 32'h0};
    vecs[3]  = '{1, 1, 2'b10, 0, 32'h00000100, 0, 0, 0, 1, 32'h00000100, 2, 32'hFFFF8001};
    vecs[4]  = '{1, 7, 2'b10, 0, 32'h00000100, 0, 0, 0, 7, 32'h00000100, 1, 32'h00000100};
    vecs[5]  = '{0, 0, 2'b00, 0, 32'h0, 1, 0, 1, 1, 32'h00000101, 7, 32'h00000100};
    vecs[6]  = '{0, 0, 2'b00, 0, 32'h0, 1, 1, 7, 7, 32'h000000FE, 1, 32'h00000101};
    vecs[7]  = '{0, 0, 2'b01, 0, 32'h0, 1, 1, 1, 1, 32'h000000FF, 7, 32'h000000FE};
    vecs[8]  = '{1, 1, 2'b10, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 32'hFFFFFFFE, 0, 32'h0};
    vecs[9]  = '{0, 0, 2'b10, 0, 32'h0, 1, 0, 1, 1, 32'h00000002, 0, 32'h0};
    vecs[10] = '{1, 4, 2'b10, 0, 32'hA5A5A5A5, 1, 0, 4, 4, 32'hA5A5A5A5, 5, 32'h0};
    vecs[11] = '{1, 4, 2'b10, 0, 32'h11111111, 1, 0, 5, 4, 32'h11111111, 5, 32'h00000004};
    vecs[12] = '{1, 3, 2'b10, 0, 32'hCAFEBABE, 0, 0, 0, 3, 32'hCAFEBABE, 0, 32'h0};
    vecs[13] = '{1, 3, 2'b01, 0, 32'h00001234, 0, 0, 0, 3, 32'hCAFE1234, 0, 32'h0};
    vecs[14] = '{1, 3, 2'b00, 1, 32'h00000080, 0, 0, 0, 3, 32'hFFFFFF80, 0, 32'h0};
    vecs[15] = '{0, 0, 2'b00, 0, 32'h0, 1, 1, 0, 0, 32'hFFFFFFFF, 3, 32'hFFFFFF80};
    vecs[16] = '{0, 0, 2'b11, 0, 32'h0, 1, 0, 0, 0, 32'h00000003, 0, 32'h00000003};
    vecs[17] = '{0, 0, 2'b01, 0, 32'h0, 1, 0, 7, 7, 32'h00000100, 0, 32'h00000003};
    vecs[18] = '{1, 6, 2'b00, 1, 32'h0000007F, 1, 1, 6, 6, 32'h0000007F, 7, 32'h00000100};

    en_a = 0; en_b = 0; sel_a = 0; sel_b = 0;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    en_a = 1; sel_a = 3; en_b = 0;
    #1;
    check("reset_q_a", q_a, 32'h0);
    check_float("reset_q_b_float", q_b);
    en_a = 0;
    #1;
    check_float("reset_q_a_float", q_a);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      s = vecs[i].s; sel_w = vecs[i].sel_w; size = vecs[i].size; sext = vecs[i].sext;
      d = vecs[i].d; adj = vecs[i].adj; adj_dec = vecs[i].adj_dec; sel_adj = vecs[i].sel_adj;
      en_a = 1; en_b = 1; sel_a = vecs[i].ra; sel_b = vecs[i].rb;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a", i), q_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), q_b, vecs[i].eb);
    end

    // Read-during-write on r0: old value in the write cycle, new after.
    @(negedge clk);
    idle();
    s = 1; sel_w = 0; size = 2'b10; d = 32'h1;
    @(negedge clk);
    d = 32'h2; en_a = 1; sel_a = 0; en_b = 0;
    #1;
    check("rdw_before_edge", q_a, 32'h1);
    @(posedge clk);
    #1;
    check("rdw_after_edge", q_a, 32'h2);
    @(negedge clk);
    idle();
    en_a = 1; en_b = 1; sel_a = 0; sel_b = 0;
    #1;
    check("dual_read_a", q_a, 32'h2);
    check("dual_read_b", q_b, 32'h2);
    en_a = 0; en_b = 0;
    #1;
    check_float("float_a_nonzero", q_a);
    check_float("float_b_nonzero", q_b);

    // Held adjust strobe repeats each edge: r5 4 -> 5 -> 6 -> 7.
    @(negedge clk);
    adj = 1; adj_dec = 0; size = 2'b00; sel_adj = 5;
    repeat (3) @(posedge clk);
    #1;
    en_a = 1; sel_a = 5;
    #1;
    check("held_adjust", q_a, 32'h7);

    // Asynchronous reset between edges while a write is pending.
    @(negedge clk);
    idle();
    s = 1; sel_w = 2; size = 2'b10; d = 32'hDEADBEEF;
    en_a = 1; sel_a = 2; en_b = 1; sel_b = 7;
    #2;
    reset = 1;
    #1;
    check("async_reset_r2", q_a, 32'h0);
    check("async_reset_r7", q_b, 32'h0);
    @(posedge clk);
    #1;
    check("reset_held_r2", q_a, 32'h0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    check("post_reset_write", q_a, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
